// File: rtl/counter_seq_ctrl.sv
// Run controller for an external enable counter.
// Optional prescaler: define COUNTER_SEQ_CTRL_PRESCALE_EN.
module counter_seq_ctrl #(
   parameter int WIDTH    = 3,
   parameter int PCNT_W   = 8,
   parameter int PRESCALE = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic              mode,
   input  logic [WIDTH-1:0]  limit,
   input  logic [WIDTH-1:0]  cnt_in,
   output logic              cnt_en,
   output logic              cnt_clr,
   output logic              busy,
   output logic              done,
   output logic              expired,
   output logic [PCNT_W-1:0] periods
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_RUN   = 3'd2,
      S_HOLD  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] limit_q;
   logic             mode_q;
   logic             tick;
   logic             accept;
   logic             term_p;

   if (PRESCALE < 1) begin : g_bad_prescale
      $error("PRESCALE must be >= 1");
   end

`ifdef COUNTER_SEQ_CTRL_PRESCALE_EN
   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PS_W-1:0] psc_q;

   assign tick = (psc_q == PS_W'(PRESCALE - 1));

   // Prescaler: advances only while actively running, holds otherwise.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         psc_q <= '0;
      end else if (state_q == S_CLEAR) begin
         psc_q <= '0;
      end else if (state_q == S_RUN && !pause && !stop) begin
         psc_q <= tick ? '0 : psc_q + 1'b1;
      end
   end
`else
   assign tick = 1'b1;
`endif

   assign busy    = (state_q == S_CLEAR) ||
                    (state_q == S_RUN)   ||
                    (state_q == S_HOLD);
   assign expired = (state_q == S_DONE);

   assign accept = ((state_q == S_IDLE) ||
                    (state_q == S_DONE)) &&
                   (state_d == S_CLEAR);

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Run configuration latched on an accepted start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         limit_q <= '0;
         mode_q  <= 1'b0;
      end else if (accept) begin
         limit_q <= limit;
         mode_q  <= mode;
      end
   end

   // Completed-period counter, cleared on each new run.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         periods <= '0;
      end else if (accept) begin
         periods <= '0;
      end else if (term_p) begin
         periods <= periods + 1'b1;
      end
   end

   // Next state and counter controls; stop overrides everything.
   always_comb begin
      state_d = state_q;
      cnt_en  = 1'b0;
      cnt_clr = 1'b0;
      done    = 1'b0;
      term_p  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            cnt_clr = 1'b1;
            state_d = S_RUN;
         end
         S_RUN: begin
            if (pause) begin
               state_d = S_HOLD;
            end else if (tick && cnt_in == limit_q) begin
               done = 1'b1;
               if (mode_q) begin
                  cnt_clr = 1'b1;
                  term_p  = 1'b1;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               cnt_en = tick;
            end
         end
         S_HOLD: begin
            if (!pause) state_d = S_RUN;
         end
         S_DONE: begin
            if (start) state_d = S_CLEAR;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (stop && state_q != S_IDLE) begin
         state_d = S_IDLE;
         cnt_en  = 1'b0;
         cnt_clr = 1'b0;
         done    = 1'b0;
         term_p  = 1'b0;
      end
   end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a
// behavioural counter closing the feedback loop.
module tb_counter_seq_ctrl;

   localparam int WIDTH    = 3;
   localparam int PCNT_W   = 8;
   localparam int PRESCALE = 4;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              start;
   logic              stop;
   logic              pause;
   logic              mode;
   logic [WIDTH-1:0]  limit;
   logic [WIDTH-1:0]  cnt;
   logic              cnt_en;
   logic              cnt_clr;
   logic              busy;
   logic              done;
   logic              expired;
   logic [PCNT_W-1:0] periods;

   int n_chk = 0;
   int n_bad = 0;

   counter_seq_ctrl #(
      .WIDTH(WIDTH),
      .PCNT_W(PCNT_W),
      .PRESCALE(PRESCALE)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .start(start),
      .stop(stop),
      .pause(pause),
      .mode(mode),
      .limit(limit),
      .cnt_in(cnt),
      .cnt_en(cnt_en),
      .cnt_clr(cnt_clr),
      .busy(busy),
      .done(done),
      .expired(expired),
      .periods(periods)
   );

   always #5 clk = ~clk;

   // The counter datapath being controlled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     cnt <= '0;
      else if (cnt_clr) cnt <= '0;
      else if (cnt_en)  cnt <= cnt + 1'b1;
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d",
                  tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   // Issue a start; returns in cycle 1 (CLEAR).
   task automatic go(input logic [WIDTH-1:0] lim,
                     input logic md);
      start = 1'b1;
      limit = lim;
      mode  = md;
      nxt();
      start = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      stop    = 1'b0;
      pause   = 1'b0;
      mode    = 1'b0;
      limit   = '0;
      repeat (2) nxt();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_exp", expired, 0);
      chk("rst_en", cnt_en, 0);
      chk("rst_clr", cnt_clr, 0);
      chk("rst_per", periods, 0);
      reset_n = 1'b1;
      nxt();

`ifdef COUNTER_SEQ_CTRL_PRESCALE_EN
      // one-shot, limit 2, dwell 4
      go(3'd2, 1'b0);
      chk("p_clr", cnt_clr, 1);
      for (int k = 2; k <= 13; k++) begin
         nxt();
         chk("p_cnt", cnt, (k - 2) / 4);
         if (k < 13) begin
            chk("p_en", cnt_en, ((k - 2) % 4) == 3);
            chk("p_done0", done, 0);
         end else begin
            chk("p_done", done, 1);
            chk("p_en_t", cnt_en, 0);
         end
      end
      nxt();
      chk("p_exp", expired, 1);
      // pause mid-dwell keeps residual count
      go(3'd2, 1'b0);
      nxt();
      chk("pp_en2", cnt_en, 0);
      nxt();
      chk("pp_en3", cnt_en, 0);
      nxt();
      pause = 1'b1;
      #1 chk("pp_en4", cnt_en, 0);
      nxt();
      chk("pp_busy", busy, 1);
      nxt();
      pause = 1'b0;
      #1 chk("pp_en6", cnt_en, 0);
      nxt();
      chk("pp_en7", cnt_en, 0);
      nxt();
      chk("pp_en8", cnt_en, 1);
      chk("pp_cnt8", cnt, 0);
      nxt();
      chk("pp_cnt9", cnt, 1);
`else
      // T1: one-shot, limit 5
      go(3'd5, 1'b0);
      chk("t1_clr", cnt_clr, 1);
      chk("t1_busy", busy, 1);
      chk("t1_en1", cnt_en, 0);
      for (int k = 2; k <= 6; k++) begin
         nxt();
         chk("t1_en", cnt_en, 1);
         chk("t1_cnt", cnt, k - 2);
      end
      nxt();
      chk("t1_done", done, 1);
      chk("t1_cnt7", cnt, 5);
      chk("t1_en7", cnt_en, 0);
      chk("t1_clr7", cnt_clr, 0);
      nxt();
      chk("t1_exp", expired, 1);
      chk("t1_busy8", busy, 0);
      chk("t1_done8", done, 0);
      repeat (2) nxt();
      chk("t1_exp_hold", expired, 1);
      chk("t1_cnt_hold", cnt, 5);

      // T2: periodic, limit 3, restart from DONE
      go(3'd3, 1'b1);
      chk("t2_clr", cnt_clr, 1);
      for (int i = 0; i < 20; i++) begin
         nxt();
         chk("t2_cnt", cnt, i % 4);
         chk("t2_done", done, (i % 4) == 3);
         chk("t2_clr", cnt_clr, (i % 4) == 3);
         chk("t2_en", cnt_en, (i % 4) != 3);
      end
      nxt();
      chk("t2_per", periods, 5);
      stop = 1'b1;
      #1 chk("t2_stop_en", cnt_en, 0);
      nxt();
      stop = 1'b0;
      chk("t2_idle", busy, 0);
      chk("t2_per_keep", periods, 5);

      // T3: pause at 2, busy start ignored
      go(3'd5, 1'b0);
      nxt();
      chk("t3_per0", periods, 0);
      chk("t3_cnt2", cnt, 0);
      start = 1'b1;
      limit = 3'd1;
      nxt();
      start = 1'b0;
      chk("t3_cnt3", cnt, 1);
      nxt();
      pause = 1'b1;
      #1 chk("t3_en4", cnt_en, 0);
      chk("t3_cnt4", cnt, 2);
      nxt();
      chk("t3_en5", cnt_en, 0);
      chk("t3_cnt5", cnt, 2);
      nxt();
      pause = 1'b0;
      #1 chk("t3_en6", cnt_en, 0);
      chk("t3_cnt6", cnt, 2);
      nxt();
      chk("t3_en7", cnt_en, 1);
      chk("t3_cnt7", cnt, 2);
      nxt();
      chk("t3_cnt8", cnt, 3);
      nxt();
      chk("t3_done9", done, 0);
      nxt();
      chk("t3_done10", done, 1);
      chk("t3_cnt10", cnt, 5);

      // T4: stop with pause and terminal
      nxt();
      go(3'd2, 1'b0);
      repeat (3) nxt();
      chk("t4_cnt", cnt, 2);
      stop  = 1'b1;
      pause = 1'b1;
      #1 chk("t4_done", done, 0);
      chk("t4_en", cnt_en, 0);
      nxt();
      stop  = 1'b0;
      pause = 1'b0;
      chk("t4_busy", busy, 0);
      chk("t4_done5", done, 0);
      chk("t4_exp", expired, 0);
      go(3'd2, 1'b0);
      chk("t4_restart", cnt_clr, 1);
      stop = 1'b1;
      nxt();
      stop = 1'b0;

      // T5: limit 0 periodic, then async reset
      go(3'd0, 1'b1);
      chk("t5_clr", cnt_clr, 1);
      chk("t5_done1", done, 0);
      for (int k = 0; k < 6; k++) begin
         nxt();
         chk("t5_done", done, 1);
         chk("t5_clr", cnt_clr, 1);
         chk("t5_en", cnt_en, 0);
         chk("t5_cnt", cnt, 0);
      end
      nxt();
      chk("t5_per", periods, 6);
      reset_n = 1'b0;
      #1 chk("t5_r_busy", busy, 0);
      chk("t5_r_done", done, 0);
      chk("t5_r_clr", cnt_clr, 0);
      chk("t5_r_en", cnt_en, 0);
      chk("t5_r_exp", expired, 0);
      chk("t5_r_per", periods, 0);
      nxt();
      reset_n = 1'b1;
`endif
      nxt();
      $display("test done: total=%0d bad=%0d",
               n_chk, n_bad);
      $finish;
   end

endmodule
